rced_et_ctrl: RTL and testbench
===============================

# rced_et_ctrl

Early-termination sequencer for the stochastic-computing Roberts-cross edge detector (rced) datapath. On `start` it loads the stream generators, runs them for up to 2^WIDTH cycles, drives the rced select stream `c`, and counts ones on the rced output `z`. It stops as soon as the thresholded edge decision can no longer change, then reports the decision, the ones count and the cycles used. It sits between the pixel-window front end and the SNG/rced datapath inside `rced_full_SC`.

## Interface
- `WIDTH`, 8: SNG/binary width. Maximum stream length N = 2^WIDTH. Counters are WIDTH+1 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a new evaluation. Accepted only in IDLE.
- `abort` in 1: synchronous cancel of a run in progress.
- `et_en` in 1: 1 = early termination enabled; 0 = always run N cycles.
- `thresh` in WIDTH+1: edge threshold in ones, range 0..N+1.
- `z` in 1: rced output bit for the current RUN cycle.
- `sng_load` out 1: one-cycle pulse that loads seeds and binary inputs into the SNGs.
- `sng_en` out 1: advances the SNGs. High in RUN only.
- `c_sel` out 1: rced select stream, equal to `cyc[0]` during RUN, 0 otherwise.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: one-cycle pulse in DONE.
- `edge_o` out 1: edge decision for the last completed run.
- `ones` out WIDTH+1: ones counted in the last completed run.
- `cycles_used` out WIDTH+1: RUN cycles consumed in the last completed run.

## Operation
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → RUN unconditionally. `sng_load`=1 in LOAD.
  - RUN → DONE on the terminate condition.
  - RUN → IDLE on `abort`.
  - DONE → IDLE unconditionally.
- `thresh` and `et_en` are captured on `start` acceptance. Changes after that do not affect the run in progress.
- On entry to LOAD, the internal counters `cnt_ones` and `cyc` are cleared.
- In each RUN cycle:
  - `ones_n` = `cnt_ones` + `z`.
  - `cyc_n` = `cyc` + 1.
  - Both are registered.
- Terminate condition, evaluated on `ones_n`/`cyc_n`:
  - `cyc_n` == N, or
  - `et_en` and `ones_n` ≥ `thresh` (edge certain), or
  - `et_en` and `ones_n` + (N − `cyc_n`) < `thresh` (edge impossible).
  - All arithmetic is unsigned, WIDTH+2 bits, so there is no overflow.
- On the terminating RUN cycle, the results are registered:
  - `edge_o` = (`ones_n` ≥ `thresh`).
  - `ones` = `ones_n`.
  - `cycles_used` = `cyc_n`.
- Result outputs hold their value until the next terminating cycle. Abort and new starts do not alter them.
- `abort` has priority over termination in the same cycle: go to IDLE, no `done`, results unchanged.
- `start` while not in IDLE is ignored. It is not queued.
- `start` and `abort` together in IDLE: `start` wins. `abort` is only meaningful in RUN.
- Boundary cases:
  - `thresh` = 0: terminates after 1 cycle with edge = 1 when `et_en`=1.
  - `thresh` = N+1: terminates after 1 cycle with edge = 0 when `et_en`=1.
  - With `et_en`=0, either case runs N cycles.

## Timing
- Reset values:
  - State = IDLE.
  - `sng_load`, `sng_en`, `c_sel`, `busy`, `done`, `edge_o` = 0.
  - `ones`, `cycles_used` = 0.
- Reset mid-run returns immediately to the IDLE/reset values.
- `start` sampled at edge t gives:
  - LOAD during t+1.
  - RUN from t+2.
  - First `z` sampled at the end of cycle t+2.
- A run terminating after K RUN cycles gives:
  - `done` high during cycle t+2+K.
  - Results valid from the same cycle.
  - IDLE at t+3+K.
  - The earliest next `start` is accepted at edge t+3+K.
- `z` must be valid combinationally in the same cycle that `sng_en` is high. The datapath has no pipeline delay.
- Control outputs are registered or decoded from state only. There is no combinational path from `z` to any output.

## Test plan
- WIDTH=4, `et_en`=0, `z`=1 constant, `thresh`=8, `start` at cycle 0:
  - RUN during cycles 2–17.
  - `done` at cycle 18.
  - `ones`=16, `cycles_used`=16, `edge_o`=1.
  - `c_sel` alternates 0,1 starting at 0.
- `et_en`=1, `z`=1, `thresh`=5 → `done` at cycle 7, `cycles_used`=5, `ones`=5, `edge_o`=1.
- `et_en`=1, `z`=0, `thresh`=5 → terminates when remaining < 5: `cycles_used`=12, `ones`=0, `edge_o`=0, `done` at cycle 14.
- `thresh`=0 → `cycles_used`=1, `edge_o`=1. `thresh`=17 → `cycles_used`=1, `edge_o`=0. Repeat with `et_en`=0 → both give `cycles_used`=16.
- Run 1 completes with `edge_o`=1, `ones`=5. Then, during run 2:
  - Pulse `start` at RUN cycle 3 → ignored.
  - Assert `abort` at RUN cycle 6 → IDLE next cycle, no `done`, results still `edge_o`=1, `ones`=5.
- Assert `rst` asynchronously mid-RUN → all outputs 0 immediately. After release, a new `start` runs normally with LOAD one cycle after the start edge.

Source files
------------

// File: rtl/rced_et_ctrl.sv
// Early-termination sequencer for the stochastic Roberts-cross edge detector.
// Loads the SNGs, runs up to 2^WIDTH cycles and stops once the edge decision is settled.
module rced_et_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             et_en,
    input  logic [WIDTH:0]   thresh,
    input  logic             z,
    output logic             sng_load,
    output logic             sng_en,
    output logic             c_sel,
    output logic             busy,
    output logic             done,
    output logic             edge_o,
    output logic [WIDTH:0]   ones,
    output logic [WIDTH:0]   cycles_used
);

    localparam logic [WIDTH+1:0] NMAX = {2'b01, {WIDTH{1'b0}}};
    localparam logic [WIDTH+1:0] ONE  = {{(WIDTH+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e         state_q, state_d;

    logic [WIDTH:0] cnt_ones_q, cnt_ones_d;
    logic [WIDTH:0] cyc_q, cyc_d;
    logic [WIDTH:0] thresh_q, thresh_d;
    logic           et_en_q, et_en_d;
    logic           edge_q, edge_d;
    logic [WIDTH:0] ones_q, ones_d;
    logic [WIDTH:0] cycles_q, cycles_d;

    logic [WIDTH+1:0] ones_n;
    logic [WIDTH+1:0] cyc_n;
    logic [WIDTH+1:0] remain;
    logic [WIDTH+1:0] ones_reach;
    logic [WIDTH+1:0] thr_ext;
    logic             edge_certain;
    logic             edge_imposs;
    logic             term;

    // Decision arithmetic is one bit wider than the counters so N+1 thresholds never wrap.
    always_comb begin
        ones_n       = {1'b0, cnt_ones_q} + {{(WIDTH+1){1'b0}}, z};
        cyc_n        = {1'b0, cyc_q} + ONE;
        remain       = NMAX - cyc_n;
        ones_reach   = ones_n + remain;
        thr_ext      = {1'b0, thresh_q};
        edge_certain = (ones_n >= thr_ext);
        edge_imposs  = (ones_reach < thr_ext);
        term         = (cyc_n == NMAX) || (et_en_q && (edge_certain || edge_imposs));
    end

    always_comb begin
        state_d    = state_q;
        cnt_ones_d = cnt_ones_q;
        cyc_d      = cyc_q;
        thresh_d   = thresh_q;
        et_en_d    = et_en_q;
        edge_d     = edge_q;
        ones_d     = ones_q;
        cycles_d   = cycles_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLoad;
                    thresh_d   = thresh;
                    et_en_d    = et_en;
                    cnt_ones_d = '0;
                    cyc_d      = '0;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                cnt_ones_d = ones_n[WIDTH:0];
                cyc_d      = cyc_n[WIDTH:0];
                // Abort outranks a same-cycle termination and leaves the results alone.
                if (abort) begin
                    state_d = StIdle;
                end else if (term) begin
                    state_d  = StDone;
                    edge_d   = edge_certain;
                    ones_d   = ones_n[WIDTH:0];
                    cycles_d = cyc_n[WIDTH:0];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_ones_q <= '0;
            cyc_q      <= '0;
            thresh_q   <= '0;
            et_en_q    <= 1'b0;
            edge_q     <= 1'b0;
            ones_q     <= '0;
            cycles_q   <= '0;
        end else begin
            cnt_ones_q <= cnt_ones_d;
            cyc_q      <= cyc_d;
            thresh_q   <= thresh_d;
            et_en_q    <= et_en_d;
            edge_q     <= edge_d;
            ones_q     <= ones_d;
            cycles_q   <= cycles_d;
        end
    end

    // Outputs depend on registered state only; z never reaches an output combinationally.
    always_comb begin
        sng_load    = (state_q == StLoad);
        sng_en      = (state_q == StRun);
        c_sel       = (state_q == StRun) && cyc_q[0];
        busy        = (state_q == StLoad) || (state_q == StRun);
        done        = (state_q == StDone);
        edge_o      = edge_q;
        ones        = ones_q;
        cycles_used = cycles_q;
    end

endmodule

// File: tb/tb_rced_et_ctrl.sv
// Bench for rced_et_ctrl at WIDTH=4: spec vector table, hand-written corner sequences and
// randomized runs scored against a stream-level model of the termination rule.
module tb_rced_et_ctrl;

    localparam int W = 4;
    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic         et_en;
    logic [W:0]   thresh;
    logic         z;
    logic         sng_load;
    logic         sng_en;
    logic         c_sel;
    logic         busy;
    logic         done;
    logic         edge_o;
    logic [W:0]   ones;
    logic [W:0]   cycles_used;

    rced_et_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .et_en       (et_en),
        .thresh      (thresh),
        .z           (z),
        .sng_load    (sng_load),
        .sng_en      (sng_en),
        .c_sel       (c_sel),
        .busy        (busy),
        .done        (done),
        .edge_o      (edge_o),
        .ones        (ones),
        .cycles_used (cycles_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit zs [N];
    int prev_ones  = 0;
    int prev_cyc   = 0;
    bit prev_edge  = 1'b0;

    typedef struct {
        int thr;
        bit et;
        int zval;
        int k;
        int o;
        bit e;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream-level reference: walk the z stream and stop once the threshold outcome is fixed.
    task automatic model(input int thr, input bit et, output int k, output int o, output bit e);
        o = 0;
        k = N;
        for (int i = 1; i <= N; i++) begin
            o += int'(zs[i-1]);
            if (et && (o >= thr || o + (N - i) < thr)) begin
                k = i;
                break;
            end
        end
        e = (o >= thr);
    endtask

    task automatic check_results(input string tag);
        chk({tag, ".edge"}, 32'(edge_o), 32'(prev_edge));
        chk({tag, ".ones"}, 32'(ones), 32'(prev_ones));
        chk({tag, ".cycles"}, 32'(cycles_used), 32'(prev_cyc));
    endtask

    // Entered and left at a negedge with the DUT idle. start_at/abort_at are RUN cycle
    // numbers (0 = never); exp_k must be in 1..N.
    task automatic run(input int thr, input bit et, input int exp_k, input int exp_o,
                       input bit exp_e, input int start_at, input int abort_at,
                       input bit abort_with_start);
        start  = 1'b1;
        abort  = abort_with_start;
        thresh = 5'(thr);
        et_en  = et;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b0;
        thresh = 5'($urandom_range(0, 31));
        et_en  = 1'($urandom_range(0, 1));
        chk("load.sng_load", 32'(sng_load), 1);
        chk("load.busy", 32'(busy), 1);
        chk("load.sng_en", 32'(sng_en), 0);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("run.sng_en", 32'(sng_en), 1);
            chk("run.busy", 32'(busy), 1);
            chk("run.c_sel", 32'(c_sel), 32'((k - 1) % 2));
            chk("run.done", 32'(done), 0);
            z     = zs[k-1];
            start = (k == start_at);
            abort = (k == abort_at);
            if (k == abort_at) begin
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                abort = 1'b0;
                chk("abort.busy", 32'(busy), 0);
                chk("abort.done", 32'(done), 0);
                check_results("abort");
                return;
            end
            if (k == exp_k) break;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        z     = 1'b0;
        chk("done.done", 32'(done), 1);
        chk("done.busy", 32'(busy), 0);
        chk("done.sng_en", 32'(sng_en), 0);
        prev_edge = exp_e;
        prev_ones = exp_o;
        prev_cyc  = exp_k;
        check_results("done");
        @(posedge clk);
        @(negedge clk);
        chk("idle.done", 32'(done), 0);
        chk("idle.busy", 32'(busy), 0);
    endtask

    task automatic fill_const(input bit v);
        for (int i = 0; i < N; i++) zs[i] = v;
    endtask

    initial begin
        int k;
        int o;
        bit e;
        int thr;
        bit et;
        int p;

        vecs[0] = '{thr: 8,  et: 1'b0, zval: 1, k: 16, o: 16, e: 1'b1};
        vecs[1] = '{thr: 5,  et: 1'b1, zval: 1, k: 5,  o: 5,  e: 1'b1};
        vecs[2] = '{thr: 5,  et: 1'b1, zval: 0, k: 12, o: 0,  e: 1'b0};
        vecs[3] = '{thr: 0,  et: 1'b1, zval: 0, k: 1,  o: 0,  e: 1'b1};
        vecs[4] = '{thr: 17, et: 1'b1, zval: 1, k: 1,  o: 1,  e: 1'b0};
        vecs[5] = '{thr: 0,  et: 1'b0, zval: 0, k: 16, o: 0,  e: 1'b1};
        vecs[6] = '{thr: 17, et: 1'b0, zval: 1, k: 16, o: 16, e: 1'b0};
        vecs[7] = '{thr: 16, et: 1'b1, zval: 1, k: 16, o: 16, e: 1'b1};

        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        et_en  = 1'b0;
        thresh = '0;
        z      = 1'b0;
        @(negedge clk);
        chk("rst.sng_load", 32'(sng_load), 0);
        chk("rst.sng_en", 32'(sng_en), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.c_sel", 32'(c_sel), 0);
        check_results("rst");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            fill_const(vecs[i].zval[0]);
            run(vecs[i].thr, vecs[i].et, vecs[i].k, vecs[i].o, vecs[i].e, 0, 0, 1'b0);
        end

        // Ignored start at RUN cycle 3, abort at RUN cycle 6.
        fill_const(1'b1);
        run(5, 1'b1, 5, 5, 1'b1, 0, 0, 1'b0);
        fill_const(1'b0);
        run(20, 1'b0, 16, 0, 1'b0, 3, 6, 1'b0);
        // Abort coinciding with the terminating cycle.
        fill_const(1'b1);
        run(2, 1'b1, 2, 2, 1'b1, 0, 2, 1'b0);
        // start and abort together in IDLE: start wins.
        fill_const(1'b0);
        run(3, 1'b1, 14, 0, 1'b0, 0, 0, 1'b1);

        // Asynchronous reset mid-run.
        start  = 1'b1;
        thresh = 5'd20;
        et_en  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.sng_en", 32'(sng_en), 0);
        chk("arst.busy", 32'(busy), 0);
        chk("arst.c_sel", 32'(c_sel), 0);
        chk("arst.sng_load", 32'(sng_load), 0);
        prev_edge = 1'b0;
        prev_ones = 0;
        prev_cyc  = 0;
        check_results("arst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_const(1'b1);
        run(7, 1'b1, 7, 7, 1'b1, 0, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            thr = $urandom_range(0, N + 1);
            et  = 1'($urandom_range(0, 1));
            p   = $urandom_range(0, 4);
            for (int i = 0; i < N; i++) zs[i] = ($urandom_range(0, 3) < p);
            model(thr, et, k, o, e);
            run(thr, et, k, o, e, $urandom_range(0, N),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, N) : 0,
                1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
